// File: rtl/deserialize_frame_pkg.sv
// Shared types and helpers for the serial frame deserializer.
// PARITY state is only reachable when PARITY_CHECK_EN is defined.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PARITY
  } deser_state_t;

  localparam int DESER_WIDTH_DEFAULT = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deserialize_frame_out_buffer.sv
// One-entry valid/ready holding register with sticky overrun detection.
// Carries a parity_error sideband alongside each buffered word.
module deser_out_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_parity_error,
  input  logic             data_ready,
  input  logic             overrun_clear,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_error,
  output logic             overrun
);

  logic consume;
  logic accept;
  logic drop;

  assign consume = data_valid & data_ready;
  assign accept  = load & (~data_valid | consume);
  assign drop    = load & data_valid & ~data_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
    end else if (accept) begin
      data_out     <= load_data;
      data_valid   <= 1'b1;
      parity_error <= load_parity_error;
    end else if (consume) begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
    end
  end

  // A fresh drop takes priority over a simultaneous clear request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/deserialize_frame.sv
// Serial-in/parallel-out receiver feeding a one-entry valid/ready buffer.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module deserialize_frame
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     serial_valid,
  input  logic                     frame_start,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     overrun,
  input  logic                     overrun_clear,
  output logic [cnt_w(WIDTH)-1:0]  bit_count,
  output logic                     parity_error
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  deser_state_t     state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] done_word;
  logic             word_done;
  logic             word_perr;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  assign shifted = shift_in(shreg, serial_in);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      count <= count_next;
    end
  end

  // frame_start wins over everything, but a coincident bit still opens the new frame.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    count_next = count;
    done_word  = '0;
    word_done  = 1'b0;
    word_perr  = 1'b0;
    if (frame_start) begin
      state_next = IDLE;
      shreg_next = '0;
      count_next = '0;
      if (serial_valid) begin
        state_next = RECV;
        shreg_next = shift_in('0, serial_in);
        count_next = CW'(1);
      end
    end else if (serial_valid) begin
      unique case (state)
        IDLE, RECV: begin
          state_next = RECV;
          shreg_next = shifted;
          count_next = count + CW'(1);
          if (count == LAST_IDX) begin
`ifdef PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = IDLE;
            shreg_next = '0;
            count_next = '0;
            done_word  = shifted;
            word_done  = 1'b1;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          state_next = IDLE;
          shreg_next = '0;
          count_next = '0;
          done_word  = shreg;
          word_done  = 1'b1;
          word_perr  = (^shreg) ^ serial_in;
        end
`endif
        default: begin
          state_next = IDLE;
          shreg_next = '0;
          count_next = '0;
        end
      endcase
    end
  end

  assign bit_count = count;

  deser_out_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buffer (
    .clock            (clock),
    .reset            (reset),
    .load             (word_done),
    .load_data        (done_word),
    .load_parity_error(word_perr),
    .data_ready       (data_ready),
    .overrun_clear    (overrun_clear),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .parity_error     (parity_error),
    .overrun          (overrun)
  );

endmodule

// File: tb/tb_deserialize_frame.sv
// Self-checking bench for deserialize_frame: directed scenarios plus randomized traffic
// against a queue-based frame model. Honours PARITY_CHECK_EN when defined.
module tb_deserialize_frame;
  import deser_pkg::*;

  localparam int WIDTH = 4;
  localparam int CW    = cnt_w(WIDTH);
`ifdef PARITY_CHECK_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic clock = 1'b0;
  logic reset, serial_in, serial_valid, frame_start, data_ready, overrun_clear;
  logic [WIDTH-1:0] d_msb, d_lsb;
  logic v_msb, v_lsb, o_msb, o_lsb, p_msb, p_lsb;
  logic [CW-1:0] bc_msb, bc_lsb;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the current frame plus the buffered word state.
  logic q[$];
  logic m_valid, m_ovr, m_perr;
  logic [WIDTH-1:0] m_msb, m_lsb;

  always #5 clock = ~clock;

  deserialize_frame #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .data_out(d_msb), .data_valid(v_msb), .data_ready(data_ready),
    .overrun(o_msb), .overrun_clear(overrun_clear), .bit_count(bc_msb), .parity_error(p_msb));

  deserialize_frame #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .data_out(d_lsb), .data_valid(v_lsb), .data_ready(data_ready),
    .overrun(o_lsb), .overrun_clear(overrun_clear), .bit_count(bc_lsb), .parity_error(p_lsb));

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
    m_msb   = '0;
    m_lsb   = '0;
  endtask

  task automatic model_clock(input logic sv, input logic b, input logic fs,
                             input logic rdy, input logic oc);
    logic done, consume, pe;
    logic [WIDTH-1:0] wm, wl;
    done = 1'b0;
    pe = 1'b0;
    wm = '0;
    wl = '0;
    consume = m_valid && rdy;
    if (fs) begin
      q.delete();
      if (sv) q.push_back(b);
    end else if (sv) begin
      q.push_back(b);
      if (q.size() == FL) begin
        done = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          wm[WIDTH-1-i] = q[i];
          wl[i]         = q[i];
        end
        for (int i = 0; i < FL; i++) pe = pe ^ q[i];
        q.delete();
      end
    end
`ifndef PARITY_CHECK_EN
    pe = 1'b0;
`endif
    if (done && m_valid && !consume) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    if (done && (!m_valid || consume)) begin
      m_valid = 1'b1;
      m_msb   = wm;
      m_lsb   = wl;
      m_perr  = pe;
    end else if (consume) begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end
  endtask

  task automatic step(input logic sv, input logic b, input logic fs,
                      input logic rdy, input logic oc);
    serial_valid  = sv;
    serial_in     = b;
    frame_start   = fs;
    data_ready    = rdy;
    overrun_clear = oc;
    @(posedge clock);
    model_clock(sv, b, fs, rdy, oc);
    #1;
    serial_valid  = 1'b0;
    serial_in     = 1'b0;
    frame_start   = 1'b0;
    data_ready    = 1'b0;
    overrun_clear = 1'b0;
  endtask

  // Presents bits[WIDTH-1] first; appends the even-parity bit when framing needs it.
  task automatic send_word(input logic [WIDTH-1:0] bits, input logic last_rdy);
    for (int i = 0; i < FL; i++)
      step(1'b1, (i < WIDTH) ? bits[WIDTH-1-i] : ^bits, 1'b0,
           (i == FL - 1) ? last_rdy : 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    serial_valid = 1'b0; serial_in = 1'b0; frame_start = 1'b0;
    data_ready = 1'b0; overrun_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    checks++; if (d_msb !== 4'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", d_msb); end
    checks++; if (v_msb !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", v_msb); end
    checks++; if (o_msb !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", o_msb); end
    checks++; if (bc_msb !== '0) begin errors++; $display("[TB] FAIL reset_bit_count: got %0d expected 0", bc_msb); end
    checks++; if (p_msb !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity: got %b expected 0", p_msb); end
    checks++; if (d_lsb !== 4'h0 || v_lsb !== 1'b0) begin errors++; $display("[TB] FAIL reset_lsb: got %h/%b expected 0/0", d_lsb, v_lsb); end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_msb_first();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++; if (bc_msb !== CW'(3)) begin errors++; $display("[TB] FAIL partial_count: got %0d expected 3", bc_msb); end
    checks++; if (v_msb !== 1'b0) begin errors++; $display("[TB] FAIL partial_valid: got %b expected 0", v_msb); end
    step(1, 1, 0, 0, 0);
`ifdef PARITY_CHECK_EN
    step(1, 1, 0, 0, 0);
`endif
    checks++; if (d_msb !== 4'hB) begin errors++; $display("[TB] FAIL msb_word: got %h expected b", d_msb); end
    checks++; if (v_msb !== 1'b1) begin errors++; $display("[TB] FAIL msb_valid: got %b expected 1", v_msb); end
    checks++; if (bc_msb !== '0) begin errors++; $display("[TB] FAIL msb_count_wrap: got %0d expected 0", bc_msb); end
    checks++; if (d_lsb !== 4'hD) begin errors++; $display("[TB] FAIL lsb_word: got %h expected d", d_lsb); end
    checks++; if (p_msb !== 1'b0) begin errors++; $display("[TB] FAIL good_parity: got %b expected 0", p_msb); end
    step(0, 0, 0, 1, 0);
    checks++; if (v_msb !== 1'b0 || v_lsb !== 1'b0) begin errors++; $display("[TB] FAIL consume: got %b/%b expected 0/0", v_msb, v_lsb); end
  endtask

  task automatic test_frame_start();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++; if (bc_msb !== '0) begin errors++; $display("[TB] FAIL resync_count: got %0d expected 0", bc_msb); end
    send_word(4'b0110, 1'b0);
    checks++; if (d_msb !== 4'h6 || v_msb !== 1'b1) begin errors++; $display("[TB] FAIL resync_word: got %h/%b expected 6/1", d_msb, v_msb); end
    checks++; if (d_lsb !== 4'h6) begin errors++; $display("[TB] FAIL resync_lsb: got %h expected 6", d_lsb); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_abort();
    for (int i = 0; i < FL - 1; i++) step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    checks++; if (v_msb !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", v_msb); end
    checks++; if (bc_msb !== CW'(1)) begin errors++; $display("[TB] FAIL abort_count: got %0d expected 1", bc_msb); end
    for (int i = 0; i < FL - 1; i++) step(1, 1, 0, 0, 0);
    checks++; if (d_msb !== 4'h7 || v_msb !== 1'b1) begin errors++; $display("[TB] FAIL abort_next: got %h/%b expected 7/1", d_msb, v_msb); end
    checks++; if (d_lsb !== 4'hE) begin errors++; $display("[TB] FAIL abort_next_lsb: got %h expected e", d_lsb); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_overrun();
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    checks++; if (d_msb !== 4'hA) begin errors++; $display("[TB] FAIL overrun_keep: got %h expected a", d_msb); end
    checks++; if (d_lsb !== 4'h5) begin errors++; $display("[TB] FAIL overrun_keep_lsb: got %h expected 5", d_lsb); end
    checks++; if (o_msb !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b expected 1", o_msb); end
    step(0, 0, 0, 0, 1);
    checks++; if (o_msb !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", o_msb); end
    checks++; if (v_msb !== 1'b1) begin errors++; $display("[TB] FAIL overrun_hold_valid: got %b expected 1", v_msb); end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 1, 0);
    checks++; if (v_msb !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", v_msb); end
    send_word(4'h3, 1'b0);
    send_word(4'hC, 1'b1);
    checks++; if (d_msb !== 4'hC || v_msb !== 1'b1) begin errors++; $display("[TB] FAIL b2b_word: got %h/%b expected c/1", d_msb, v_msb); end
    checks++; if (d_lsb !== 4'h3) begin errors++; $display("[TB] FAIL b2b_lsb: got %h expected 3", d_lsb); end
    checks++; if (o_msb !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", o_msb); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_parity();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
`ifdef PARITY_CHECK_EN
    checks++; if (v_msb !== 1'b0 || bc_msb !== CW'(4)) begin errors++; $display("[TB] FAIL parity_wait: got %b/%0d expected 0/4", v_msb, bc_msb); end
    step(1, 0, 0, 0, 0);
    checks++; if (d_msb !== 4'hB || p_msb !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad: got %h/%b expected b/1", d_msb, p_msb); end
    step(0, 0, 0, 1, 0);
    checks++; if (p_msb !== 1'b0) begin errors++; $display("[TB] FAIL parity_consume: got %b expected 0", p_msb); end
    send_word(4'hB, 1'b0);
    checks++; if (p_msb !== 1'b0 || v_msb !== 1'b1) begin errors++; $display("[TB] FAIL parity_good: got %b/%b expected 0/1", p_msb, v_msb); end
`else
    checks++; if (p_msb !== 1'b0 || p_lsb !== 1'b0) begin errors++; $display("[TB] FAIL parity_tied: got %b/%b expected 0/0", p_msb, p_lsb); end
`endif
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_midframe();
    send_word(4'h9, 1'b0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (v_msb !== 1'b0 || d_msb !== 4'h0) begin errors++; $display("[TB] FAIL async_reset_buf: got %b/%h expected 0/0", v_msb, d_msb); end
    checks++; if (bc_msb !== '0 || bc_lsb !== '0) begin errors++; $display("[TB] FAIL async_reset_count: got %0d/%0d expected 0/0", bc_msb, bc_lsb); end
    model_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    logic sv, b, fs, rdy, oc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sv  = ($urandom_range(0, 9) < 7);
      b   = 1'($urandom);
      fs  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      oc  = ($urandom_range(0, 9) == 0);
      step(sv, b, fs, rdy, oc);
      checks++;
      if (d_msb !== m_msb || d_lsb !== m_lsb || v_msb !== m_valid || v_lsb !== m_valid) begin
        errors++;
        $display("[TB] FAIL rand_data[%0d]: got %h/%h/%b expected %h/%h/%b", n, d_msb, d_lsb, v_msb, m_msb, m_lsb, m_valid);
      end
      checks++;
      if (o_msb !== m_ovr || o_lsb !== m_ovr || p_msb !== m_perr || bc_msb !== CW'(q.size())) begin
        errors++;
        $display("[TB] FAIL rand_status[%0d]: got ovr=%b perr=%b cnt=%0d expected ovr=%b perr=%b cnt=%0d",
                 n, o_msb, p_msb, bc_msb, m_ovr, m_perr, q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_frame_start();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
